histogram_eq_master_fsm: RTL and testbench

HISTOGRAM_EQ_MASTER_FSM -- requirements
Module: histogram_eq_master_fsm

---
 rtl/histogram_eq_pkg.sv | 22 ++
 rtl/histogram_eq_master_fsm_stage_timer.sv | 34 +++
 rtl/histogram_eq_master_fsm.sv | 158 +++++++++++++++
 tb/tb_histogram_eq_master_fsm.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/histogram_eq_pkg.sv
// Shared types and defaults for the histogram-equalization frame sequencer.
// Holds the state encoding, default parameters and the saturating increment.
package histogram_eq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HIST  = 3'd1,
        ST_CDF   = 3'd2,
        ST_DIV   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

    localparam logic [15:0] DEFAULT_LAST_INPUT_ADDR = 16'd4095;
    localparam logic [31:0] DEFAULT_TIMEOUT_CYCLES  = 32'd200000;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/histogram_eq_master_fsm_stage_timer.sv
// Per-stage cycle counter: synchronous clear, saturating count while enabled,
// and a flag raised on the last cycle allowed before the watchdog expires.
module stage_timer
    import histogram_eq_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [31:0] count,
    output logic        timeout
);

    // Compared at 33 bits so TIMEOUT_CYCLES=0 can never match a real count.
    localparam logic [32:0] TIMEOUT_LAST = {1'b0, TIMEOUT_CYCLES} - 33'd1;

    logic [31:0] count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= sat_inc(count_reg);
        end
    end

    assign count   = count_reg;
    assign timeout = enable && ({1'b0, count_reg} == TIMEOUT_LAST);

endmodule

// File: rtl/histogram_eq_master_fsm.sv
// Frame sequencer for histogram equalization: runs histogram, CDF and divider
// stages in order, with a per-stage watchdog, abort and per-stage durations.
module histogram_eq_master_fsm
    import histogram_eq_pkg::*;
#(
    parameter logic [15:0] LAST_INPUT_ADDR = DEFAULT_LAST_INPUT_ADDR,
    parameter logic [31:0] TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] histogram_input_mem_raddr0,
    input  logic [15:0] histogram_input_mem_raddr1,
    input  logic        histogram_computation_done,
    input  logic        cdf_done,
    input  logic        divider_done,
    output logic        start_histogram,
    output logic        start_cdf,
    output logic        start_divider,
    output logic        input_mem_read_finished,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] hist_cycles,
    output logic [31:0] cdf_cycles,
    output logic [31:0] div_cycles
);

    state_e            state_reg;
    state_e            state_next;
    logic [2:0]        stage_sel;
    logic              in_stage;
    logic              stage_timeout;
    logic              timer_clear;
    logic              frame_start;
    logic              stage_exit;
    logic [31:0]       stage_count;
    logic [31:0]       latch_value;
    logic [1:0]        addr_hit;
    logic              read_finished_reg;
    logic              read_finished_next;
    logic [2:0][31:0]  cycles_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Abort wins over everything; a stage's own done flag wins over its timeout.
    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (start) state_next = ST_HIST;
                ST_HIST:  if (histogram_computation_done) state_next = ST_CDF;
                          else if (stage_timeout)         state_next = ST_ERROR;
                ST_CDF:   if (cdf_done)                   state_next = ST_DIV;
                          else if (stage_timeout)         state_next = ST_ERROR;
                ST_DIV:   if (divider_done)               state_next = ST_DONE;
                          else if (stage_timeout)         state_next = ST_ERROR;
                ST_DONE:  state_next = ST_IDLE;
                ST_ERROR: state_next = ST_ERROR;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        start_histogram = 1'b0;
        start_cdf       = 1'b0;
        start_divider   = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        error           = 1'b0;
        case (state_reg)
            ST_HIST:  begin start_histogram = 1'b1; busy = 1'b1; end
            ST_CDF:   begin start_cdf       = 1'b1; busy = 1'b1; end
            ST_DIV:   begin start_divider   = 1'b1; busy = 1'b1; end
            ST_DONE:  done  = 1'b1;
            ST_ERROR: error = 1'b1;
            default:  ;
        endcase
    end

    assign stage_sel = {state_reg == ST_DIV, state_reg == ST_CDF, state_reg == ST_HIST};
    assign in_stage  = |stage_sel;

    // Any state change restarts the count, so every stage begins at zero.
    assign timer_clear = (state_next != state_reg);

    stage_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stage_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (in_stage),
        .count   (stage_count),
        .timeout (stage_timeout)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_addr_hit
            assign addr_hit[gi] = (((gi == 0) ? histogram_input_mem_raddr0
                                              : histogram_input_mem_raddr1) == LAST_INPUT_ADDR);
        end
    endgenerate

    always_comb begin
        read_finished_next = read_finished_reg;
        if (state_next == ST_IDLE || (state_next == ST_HIST && state_reg != ST_HIST)) begin
            read_finished_next = 1'b0;
        end else if (state_reg == ST_HIST && (|addr_hit)) begin
            read_finished_next = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_finished_reg <= 1'b0;
        end else begin
            read_finished_reg <= read_finished_next;
        end
    end

    assign input_mem_read_finished = read_finished_reg;

    // Durations are captured on a done or timeout exit; an aborted stage keeps the old value.
    assign frame_start = (state_reg == ST_IDLE) && start && !abort;
    assign stage_exit  = in_stage && !abort && (state_next != state_reg);
    assign latch_value = sat_inc(stage_count);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycles_reg <= '0;
        end else if (frame_start) begin
            cycles_reg <= '0;
        end else if (stage_exit) begin
            for (int i = 0; i < 3; i++) begin
                if (stage_sel[i]) begin
                    cycles_reg[i] <= latch_value;
                end
            end
        end
    end

    assign hist_cycles = cycles_reg[0];
    assign cdf_cycles  = cycles_reg[1];
    assign div_cycles  = cycles_reg[2];

endmodule

// File: tb/tb_histogram_eq_master_fsm.sv
// Randomized scoreboard bench for the equalization frame sequencer, plus a
// second instance with a short watchdog for timeout and priority scenarios.
module tb_histogram_eq_master_fsm;

    localparam logic [15:0] LAST = 16'd4095;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, start, abort, hdone, cdone, ddone;
    logic [15:0] raddr0, raddr1;
    logic        start_histogram, start_cdf, start_divider, rf, busy, done, error;
    logic [31:0] hist_cycles, cdf_cycles, div_cycles;

    logic        w_reset, w_start, w_abort, w_hdone, w_cdone, w_ddone;
    logic [15:0] w_raddr0, w_raddr1;
    logic        w_start_histogram, w_start_cdf, w_start_divider, w_rf, w_busy, w_done, w_error;
    logic [31:0] w_hist_cycles, w_cdf_cycles, w_div_cycles;

    histogram_eq_master_fsm dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .histogram_input_mem_raddr0(raddr0), .histogram_input_mem_raddr1(raddr1),
        .histogram_computation_done(hdone), .cdf_done(cdone), .divider_done(ddone),
        .start_histogram(start_histogram), .start_cdf(start_cdf), .start_divider(start_divider),
        .input_mem_read_finished(rf), .busy(busy), .done(done), .error(error),
        .hist_cycles(hist_cycles), .cdf_cycles(cdf_cycles), .div_cycles(div_cycles)
    );

    histogram_eq_master_fsm #(.TIMEOUT_CYCLES(32'd50)) dut_wd (
        .clock(clock), .reset(w_reset), .start(w_start), .abort(w_abort),
        .histogram_input_mem_raddr0(w_raddr0), .histogram_input_mem_raddr1(w_raddr1),
        .histogram_computation_done(w_hdone), .cdf_done(w_cdone), .divider_done(w_ddone),
        .start_histogram(w_start_histogram), .start_cdf(w_start_cdf), .start_divider(w_start_divider),
        .input_mem_read_finished(w_rf), .busy(w_busy), .done(w_done), .error(w_error),
        .hist_cycles(w_hist_cycles), .cdf_cycles(w_cdf_cycles), .div_cycles(w_div_cycles)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outcome of a completed frame, pushed when the frame is issued.
    typedef struct {
        int h;
        int c;
        int d;
        bit rf;
    } frame_t;

    frame_t sb_q[$];
    frame_t mon_e;
    int     hcnt = 0, ccnt = 0, dcnt = 0;
    logic   prev_hist = 1'b0, prev_done = 1'b0;

    // Monitor: measures enable lengths and scores each done pulse against the queue.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            chk1("enable_overlap", ($countones({start_histogram, start_cdf, start_divider}) > 1), 1'b0);
            if (start_histogram && !prev_hist) begin
                hcnt = 0; ccnt = 0; dcnt = 0;
            end
            if (start_histogram) hcnt++;
            if (start_cdf)       ccnt++;
            if (start_divider)   dcnt++;
            if (done) begin
                chk1("done_width", prev_done, 1'b0);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk32("hist_cycles", hist_cycles, mon_e.h);
                    chk32("cdf_cycles", cdf_cycles, mon_e.c);
                    chk32("div_cycles", div_cycles, mon_e.d);
                    chk32("hist_enable_len", hcnt, mon_e.h);
                    chk32("cdf_enable_len", ccnt, mon_e.c);
                    chk32("div_enable_len", dcnt, mon_e.d);
                    chk1("rf_at_done", rf, mon_e.rf);
                    chk1("busy_at_done", busy, 1'b0);
                end
            end
            prev_hist = start_histogram;
            prev_done = done;
        end
    end

    function automatic logic en_of(input int which);
        case (which)
            0:       return start_histogram;
            1:       return start_cdf;
            default: return start_divider;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        chk1({tag, "_en"}, start_histogram | start_cdf | start_divider, 1'b0);
        chk1({tag, "_rf"}, rf, 1'b0);
        chk1({tag, "_status"}, busy | done | error, 1'b0);
        chk32({tag, "_cycles"}, hist_cycles | cdf_cycles | div_cycles, 32'd0);
    endtask

    // Holds stage 'which' for k cycles, its done flag sampled on cycle k; other
    // done flags are noise. match_cyc is the cycle that presents LAST on a port.
    task automatic run_stage(input int which, input int k, input int match_cyc,
                             input bit do_abort, input bit exp_rf, output bit ok);
        int waited = 0;
        bit seen = 0;
        bit matched = 0;
        ok = 0;
        for (int w = 0; w < 8 && !seen; w++) begin
            @(negedge clock);
            waited++;
            seen = en_of(which);
        end
        chk1("stage_enable_seen", seen, 1'b1);
        if (!seen) return;
        chk32("stage_gap", waited, 32'd1);
        if (which == 1) chk1("rf_at_cdf_entry", rf, exp_rf);
        for (int i = 1; i <= k; i++) begin
            if (i > 1) begin
                @(posedge clock);
                #1;
                chk1("stage_held", en_of(which), 1'b1);
            end else begin
                #1;
            end
            if (which == 0) chk1("rf_during_hist", rf, matched);
            if (!(which == 0 && i == 1)) start = 1'b0;
            hdone = (which == 0) ? (i == k) : ((i < k) && ($urandom_range(0, 3) == 0));
            cdone = (which == 1) ? (i == k) : ((i < k) && ($urandom_range(0, 3) == 0));
            ddone = (which == 2) ? (i == k)
                                 : ((i < k) && (($urandom_range(0, 3) == 0) || (which == 0 && i == 1)));
            abort = do_abort && (i == k);
            if (match_cyc == i) begin
                if (i % 2 == 0) begin
                    raddr1 = LAST;
                    raddr0 = 16'($urandom_range(0, 4094));
                end else begin
                    raddr0 = LAST;
                    raddr1 = 16'($urandom_range(0, 4094));
                end
                if (which == 0) matched = 1;
            end else begin
                raddr0 = 16'($urandom_range(0, 4094));
                raddr1 = 16'($urandom_range(0, 4094));
            end
        end
        @(posedge clock);
        #1;
        hdone = 0; cdone = 0; ddone = 0; abort = 0;
        raddr0 = 16'd0; raddr1 = 16'd0;
        ok = 1;
    endtask

    // mode 0: complete frame; 1: abort together with cdf_done on CDF cycle j;
    // 2: asynchronous reset on DIV cycle j. mc_force<0 picks the match cycle randomly.
    task automatic run_frame(input int h, input int c, input int d,
                             input int mode, input int j, input int mc_force);
        frame_t e;
        bit ok;
        int mc;
        if (mc_force >= 0) mc = mc_force;
        else mc = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, h));
        e.h = h; e.c = c; e.d = d; e.rf = (mc != 0);
        if (mode == 0) sb_q.push_back(e);
        $display("frame h=%0d c=%0d d=%0d mode=%0d j=%0d match=%0d", h, c, d, mode, j, mc);
        @(posedge clock);
        #1;
        start = 1'b1;
        @(negedge clock);
        chk1("hist_not_early", start_histogram, 1'b0);
        chk1("busy_idle", busy, 1'b0);
        @(posedge clock);
        #1;
        chk1("hist_after_start", start_histogram, 1'b1);
        run_stage(0, h, mc, 1'b0, 1'b0, ok);
        if (!ok) return;
        if (mode == 1) begin
            run_stage(1, j, int'($urandom_range(1, j)), 1'b1, mc != 0, ok);
            if (!ok) return;
            chk1("abort_enables", start_histogram | start_cdf | start_divider, 1'b0);
            chk1("abort_status", busy | done | error, 1'b0);
            chk1("abort_rf", rf, 1'b0);
            chk32("abort_hist_kept", hist_cycles, h);
            chk32("abort_cdf_cycles", cdf_cycles, 32'd0);
            chk32("abort_div_cycles", div_cycles, 32'd0);
            @(negedge clock);
            chk1("abort_stays_idle", busy | start_divider, 1'b0);
            return;
        end
        run_stage(1, c, int'($urandom_range(1, c)), 1'b0, mc != 0, ok);
        if (!ok) return;
        if (mode == 2) begin
            @(negedge clock);
            repeat (j - 1) @(negedge clock);
            chk1("div_before_reset", start_divider, 1'b1);
            #2;
            reset = 1'b0;
            #1;
            check_all_zero("async_reset");
            @(posedge clock);
            #1;
            reset = 1'b1;
            repeat (2) @(negedge clock);
            check_all_zero("after_reset");
            return;
        end
        run_stage(2, d, int'($urandom_range(1, d)), 1'b0, mc != 0, ok);
        if (!ok) return;
        @(negedge clock);
        chk1("done_pulse", done, 1'b1);
        @(negedge clock);
        chk1("busy_after", busy, 1'b0);
        chk1("done_after", done, 1'b0);
        chk1("rf_idle", rf, 1'b0);
    endtask

    task automatic wd_step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 0; start = 0; abort = 0; hdone = 0; cdone = 0; ddone = 0;
        raddr0 = 0; raddr1 = 0;
        w_reset = 0; w_start = 0; w_abort = 0; w_hdone = 0; w_cdone = 0; w_ddone = 0;
        w_raddr0 = 0; w_raddr1 = 0;
        #1;
        check_all_zero("reset_state");
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        check_all_zero("reset_held");
        start = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        w_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk1("idle_after_release", busy | start_histogram, 1'b0);
        end

        run_frame(100, 40, 300, 0, 0, 60);
        for (int n = 0; n < 12; n++) begin
            run_frame(int'($urandom_range(1, 30)), int'($urandom_range(1, 30)),
                      int'($urandom_range(1, 30)), 0, 0, -1);
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end
        for (int n = 0; n < 3; n++) begin
            int c_len;
            c_len = int'($urandom_range(2, 20));
            run_frame(int'($urandom_range(1, 20)), c_len, 10, 1, int'($urandom_range(1, c_len)), -1);
            run_frame(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)),
                      int'($urandom_range(1, 20)), 0, 0, -1);
        end
        run_frame(15, 12, 20, 2, int'($urandom_range(1, 19)), -1);
        run_frame(int'($urandom_range(1, 25)), int'($urandom_range(1, 25)),
                  int'($urandom_range(1, 25)), 0, 0, -1);

        // Watchdog instance: histogram done on cycle 10, then cdf_done withheld.
        $display("watchdog frame: hist 10, cdf withheld");
        wd_step();
        w_start = 1'b1;
        wd_step();
        w_start = 1'b0;
        chk1("wd_hist_on", w_start_histogram, 1'b1);
        repeat (9) wd_step();
        w_hdone = 1'b1;
        wd_step();
        w_hdone = 1'b0;
        chk1("wd_cdf_entry", w_start_cdf, 1'b1);
        for (int i = 2; i <= 50; i++) begin
            wd_step();
            chk1("wd_cdf_alive", w_start_cdf & !w_error, 1'b1);
        end
        wd_step();
        chk1("wd_error", w_error, 1'b1);
        chk1("wd_enables_off", w_start_histogram | w_start_cdf | w_start_divider, 1'b0);
        chk1("wd_busy_off", w_busy, 1'b0);
        chk32("wd_hist_cycles", w_hist_cycles, 32'd10);
        chk32("wd_cdf_cycles", w_cdf_cycles, 32'd50);
        w_start = 1'b1; w_cdone = 1'b1; w_ddone = 1'b1; w_hdone = 1'b1;
        repeat (3) begin
            wd_step();
            chk1("wd_error_sticky", w_error & !w_busy, 1'b1);
        end
        w_start = 1'b0; w_cdone = 1'b0; w_ddone = 1'b0; w_hdone = 1'b0;
        w_abort = 1'b1;
        wd_step();
        w_abort = 1'b0;
        chk1("wd_abort_clears_error", w_error | w_busy, 1'b0);
        chk32("wd_cycles_kept", w_cdf_cycles, 32'd50);

        // Done flag coinciding with the timeout cycle must win.
        $display("watchdog frame: hist done on cycle 50");
        w_start = 1'b1;
        wd_step();
        w_start = 1'b0;
        repeat (49) wd_step();
        w_hdone = 1'b1;
        wd_step();
        w_hdone = 1'b0;
        chk1("wd_prio_cdf", w_start_cdf & !w_error, 1'b1);
        chk32("wd_prio_hist_cycles", w_hist_cycles, 32'd50);
        chk32("wd_prio_cdf_cleared", w_cdf_cycles, 32'd0);
        w_cdone = 1'b1;
        wd_step();
        w_cdone = 1'b0;
        chk1("wd_prio_div", w_start_divider, 1'b1);
        w_ddone = 1'b1;
        wd_step();
        w_ddone = 1'b0;
        chk1("wd_prio_done", w_done, 1'b1);
        chk32("wd_prio_div_cycles", w_div_cycles, 32'd1);

        repeat (3) @(negedge clock);
        chk32("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
